ws2811_encoder: RTL and testbench
=================================

# ws2811_encoder

Serial line encoder that sits downstream of the byte FIFO in the USB-to-LED path. It pops GRB bytes from the FIFO read port and drives the WS2811 data line MSB-first, one 1.25 µs cell per bit at the 12.8 MHz pixel clock. After `3*LED_COUNT` bytes it holds the line low for the latch/reset interval. It replaces the ad-hoc subcell mux with a clean frame state machine that handles FIFO underruns.

## Interface
Parameters:
- `LED_COUNT`, 50: LEDs per frame; frame length is `3*LED_COUNT` bytes. Must be ≥1.
- `BIT_CYCLES`, 16: clk cycles per bit cell (16 × 78.125 ns = 1.25 µs).
- `T0H_CYCLES`, 4: high time for a 0 bit (0.3125 µs).
- `T1H_CYCLES`, 12: high time for a 1 bit (0.9375 µs).
- `RESET_CYCLES`, 1024: low time for latch (80 µs, above the 50 µs minimum). Also used as the underrun resync threshold.
- Required ordering: `0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES`.

Ports:
- `clk` in 1: pixel clock, 12.8 MHz. This block uses one clock only.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: FIFO not empty (show-ahead FIFO; the tie is `~rdempty`).
- `in_data` in 8: FIFO head byte (`q`).
- `in_ready` out 1: pop strobe. A transfer occurs when `in_valid & in_ready`; the tie is `rdreq = in_valid & in_ready`.
- `ws2811` out 1: registered serial data line.
- `busy` out 1: high in any state other than IDLE.
- `frame_done` out 1: one-cycle pulse at the end of the latch interval.
- `underrun` out 1: one-cycle pulse when a mid-frame gap reaches `RESET_CYCLES`.

## Operation
- States are IDLE, SEND, GAP and LATCH.
- Internal registers:
  - `shreg[7:0]`
  - `bit_idx` (0..7)
  - `cell_cnt` (0..BIT_CYCLES-1)
  - `byte_cnt` (0..3*LED_COUNT-1)
  - `gap_cnt` (0..RESET_CYCLES)
- IDLE:
  - `in_ready` = 1 and `ws2811` = 0.
  - On a transfer: load `shreg`, set `bit_idx`=7 and `cell_cnt`=0, then go to SEND.
- SEND:
  - `ws2811` is high while `cell_cnt` < (`shreg[bit_idx]` ? T1H : T0H), and low otherwise.
  - `cell_cnt` wraps at BIT_CYCLES-1. On each wrap, `bit_idx` decrements.
- End of byte (`bit_idx`=0 and `cell_cnt`=BIT_CYCLES-1):
  - If `byte_cnt`=3*LED_COUNT-1: clear `byte_cnt` and go to LATCH. `in_ready` = 0.
  - Otherwise `byte_cnt` increments. `in_ready` = 1 in this cycle only.
  - If a transfer occurs, the next byte starts back-to-back with no dead cycle.
  - If no transfer occurs, clear `gap_cnt` and go to GAP.
- GAP:
  - `ws2811` = 0 and `in_ready` = 1.
  - On a transfer, start the byte as in IDLE.
  - Otherwise `gap_cnt` increments. When it reaches RESET_CYCLES: pulse `underrun`, clear `byte_cnt` (resync with the LEDs, which have latched), and go to IDLE.
  - If a transfer and the threshold occur in the same cycle, the transfer wins.
- LATCH:
  - `ws2811` = 0 and `in_ready` = 0 for RESET_CYCLES cycles.
  - Then pulse `frame_done` and go to IDLE.
- `in_ready` is never asserted in SEND except on the end-of-byte cycle.
- While `in_valid`=0 the `in_data` value is ignored.
- Asserting `rst` mid-bit forces `ws2811` low immediately (asynchronous). All counters clear. The next frame begins at byte 0.

## Timing
- Reset values: `ws2811`=0, `in_ready`=1 (IDLE), `busy`=0, `frame_done`=0, `underrun`=0.
- Latency: a transfer at cycle t in IDLE or GAP gives `ws2811` high at t+1.
- A bit cell is exactly BIT_CYCLES cycles. A back-to-back frame of N bytes lasts exactly `N*8*BIT_CYCLES + RESET_CYCLES` cycles plus the 1-cycle IDLE entry.
- `frame_done` is asserted in the final LATCH cycle. The next transfer is accepted in the following cycle at the earliest.
- All outputs are registered and glitch-free, because `ws2811` drives an off-board line.
- Counter widths use `$clog2` of their maxima. `gap_cnt` saturates and does not wrap.

## Structure
- Package `ws2811_pkg` holds:
  - the state enum (IDLE/SEND/GAP/LATCH)
  - the default timing constants `WS_BIT_CYCLES`, `WS_T0H_CYCLES`, `WS_T1H_CYCLES`, `WS_RESET_CYCLES`, shared with the clock-generation top level.
- One natural sub-module is `ws2811_cell`. It takes a start strobe and a bit value, produces the high/low waveform over BIT_CYCLES, and raises `cell_last`. The frame FSM stays in `ws2811_encoder`.
- The top level instantiates `ws2811_encoder` on `clk12_8` in place of the subcell mux logic.

## Test plan
- **Single bytes.** LED_COUNT=1; push 0x80, 0x00, 0xFF with `in_valid` held. Expect:
  - bit 7 of byte 0 is high for 12 cycles, then low for 4.
  - all bits of byte 1 are high for 4, then low for 12.
  - the line is low for 1024 cycles after byte 2, then `frame_done` pulses once.
- **Back-to-back frame.** LED_COUNT=2, FIFO preloaded with 6 bytes. Expect:
  - `in_ready`&`in_valid` exactly 6 times, with no idle cycle between bytes.
  - total busy time of 768+1024 cycles.
- **Short underrun.** Drop `in_valid` for 200 cycles after byte 1, then resume. Expect the line low during the gap, no `underrun`, the frame completing at byte 5, and `frame_done`.
- **Long underrun.** Drop `in_valid` for 1100 cycles after byte 1. Expect `underrun` at gap cycle 1024, IDLE, and the next byte counted as byte 0 of a new frame.
- **Reset mid-bit.** Assert `rst` at `cell_cnt`=6 of a 1 bit. Expect `ws2811`=0 and `in_ready`=1 with no clock edge. After release, the next frame restarts at byte 0.
- **Threshold race.** `in_valid` rises exactly at gap cycle 1024. Expect the transfer to be accepted, no `underrun` pulse, and `byte_cnt` to continue.

Source files
------------

// File: rtl/ws2811_encoder_pkg.sv
// ws2811_pkg: shared frame state encoding and default WS2811 timing at 12.8 MHz
package ws2811_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAP   = 2'd2,
    LATCH = 2'd3
  } ws_state_e;
  localparam int WS_BIT_CYCLES   = 16;
  localparam int WS_T0H_CYCLES   = 4;
  localparam int WS_T1H_CYCLES   = 12;
  localparam int WS_RESET_CYCLES = 1024;
endpackage

// File: rtl/ws2811_encoder_if.sv
// ws2811_encoder_if: show-ahead FIFO read port feeding the encoder
interface ws2811_encoder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  modport master (output in_valid, output in_data, input in_ready);
  modport slave (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ws2811_encoder_cell.sv
// ws2811_cell: one bit cell, high for T0H/T1H cycles then low until BIT_CYCLES
module ws2811_cell
  import ws2811_pkg::*;
#(
  parameter int BIT_CYCLES = WS_BIT_CYCLES,
  parameter int T0H_CYCLES = WS_T0H_CYCLES,
  parameter int T1H_CYCLES = WS_T1H_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic line,
  output logic cell_last,
  output logic cell_pre
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0 = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1 = CW'(T1H_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic bit_q, bit_d, active_q, active_d, line_q, line_d, last_q;
  // next cell position; a start on the last cycle chains cells with no dead cycle
  always_comb begin
    cnt_d = start ? '0 : (active_q ? ((cnt_q == LAST) ? '0 : cnt_q + 1'b1) : cnt_q);
    bit_d = start ? bit_val : bit_q;
    active_d = start | (active_q & (cnt_q != LAST));
    line_d = active_d & (cnt_d < (bit_d ? T1 : T0));
    cell_pre = active_d & (cnt_d == LAST);
  end
  // line and last flag come from next-state values so the pin is a clean flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      bit_q <= 1'b0;
      active_q <= 1'b0;
      line_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      active_q <= active_d;
      line_q <= line_d;
      last_q <= cell_pre;
    end
  end
  assign line = line_q;
  assign cell_last = last_q;
endmodule

// File: rtl/ws2811_encoder.sv
// ws2811_encoder: frame FSM popping GRB bytes and serialising them onto the WS2811 line
module ws2811_encoder
  import ws2811_pkg::*;
#(
  parameter int LED_COUNT    = 50,
  parameter int BIT_CYCLES   = WS_BIT_CYCLES,
  parameter int T0H_CYCLES   = WS_T0H_CYCLES,
  parameter int T1H_CYCLES   = WS_T1H_CYCLES,
  parameter int RESET_CYCLES = WS_RESET_CYCLES
) (
  input  logic clk,
  input  logic rst,
  ws2811_encoder_if.slave s,
  output logic ws2811,
  output logic busy,
  output logic frame_done,
  output logic underrun
);
  localparam int FRAME = 3 * LED_COUNT;
  localparam int BW = $clog2(FRAME);
  localparam int GW = $clog2(RESET_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(RESET_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(RESET_CYCLES - 1);
  ws_state_e state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic in_ready_q, in_ready_d, busy_q, busy_d;
  logic frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic xfer, start, bit_val, cell_last, cell_pre;
  assign xfer = s.in_valid & in_ready_q;
  ws2811_cell #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES)
  ) u_cell (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bit_val(bit_val),
    .line(ws2811),
    .cell_last(cell_last),
    .cell_pre(cell_pre)
  );
  // frame sequencing; an accepted byte always wins, including over the underrun threshold
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_idx_d = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d = gap_cnt_q;
    start = 1'b0;
    bit_val = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      SEND: if (cell_last) begin
        if (bit_idx_q != 3'd0) begin
          bit_idx_d = bit_idx_q - 3'd1;
          start = 1'b1;
          bit_val = shreg_q[bit_idx_q - 3'd1];
        end else if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_d = '0;
          gap_cnt_d = '0;
          state_d = LATCH;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          gap_cnt_d = '0;
          state_d = GAP;
        end
      end
      LATCH: if (gap_cnt_q == GAP_LAST) state_d = IDLE;
             else gap_cnt_d = gap_cnt_q + 1'b1;
      GAP: if (!xfer) begin
        gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          underrun_d = 1'b1;
          byte_cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (xfer) begin
      state_d = SEND;
      shreg_d = s.in_data;
      bit_idx_d = 3'd7;
      start = 1'b1;
      bit_val = s.in_data[7];
    end
    in_ready_d = (state_d == IDLE) | (state_d == GAP) |
                 ((state_d == SEND) & (bit_idx_d == 3'd0) & cell_pre & (byte_cnt_d != LAST_BYTE));
    busy_d = state_d != IDLE;
    frame_done_d = (state_d == LATCH) & (gap_cnt_d == GAP_LAST);
  end
  // state and registered status outputs; reset returns to IDLE ready for byte 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_idx_q <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q <= '0;
      in_ready_q <= 1'b1;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_idx_q <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q <= underrun_d;
    end
  end
  assign s.in_ready = in_ready_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_ws2811_encoder.sv
// tb_ws2811_encoder: decodes the serial line back into bytes and checks framing rules
module tb_ws2811_encoder;
  localparam int LEDS = 2;
  localparam int FRAME = 3 * LEDS;
  localparam int BIT = 16;
  localparam int T0H = 4;
  localparam int T1H = 12;
  localparam int RST_CYC = 1024;
  localparam int BYTE_T = 8 * BIT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ws2811, busy, frame_done, underrun;
  ws2811_encoder_if bus();
  ws2811_encoder #(
    .LED_COUNT(LEDS), .BIT_CYCLES(BIT), .T0H_CYCLES(T0H),
    .T1H_CYCLES(T1H), .RESET_CYCLES(RST_CYC)
  ) dut (
    .clk(clk), .rst(rst), .s(bus), .ws2811(ws2811),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic src_en = 1'b0;
  logic [7:0] fifo[$], txq[$], rxq[$];
  int pop_ticks[$], rise_q[$];
  int busy_cnt, n_fd, fd_tick, n_ur, ur_tick, hi_run, last_hi, bad_runs, nbits;
  int p, k, gap_hi, gap_rdy, odd;
  logic [7:0] bits;
  logic prev_ws;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    txq.delete(); rxq.delete(); pop_ticks.delete(); rise_q.delete();
    busy_cnt = 0; n_fd = 0; fd_tick = 0; n_ur = 0; ur_tick = 0;
    hi_run = 0; last_hi = cyc; bad_runs = 0; nbits = 0; bits = '0; prev_ws = ws2811;
  endtask

  task automatic push_rand(input int n);
    repeat (n) fifo.push_back(8'($urandom));
  endtask

  // one clock: account the transfer at this edge, then sample and decode the line
  task automatic tick();
    cyc++;
    if (bus.in_valid && bus.in_ready && !rst) begin
      pop_ticks.push_back(cyc);
      txq.push_back(fifo.pop_front());
    end
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (frame_done) begin n_fd++; fd_tick = cyc; end
    if (underrun) begin n_ur++; ur_tick = cyc; end
    if (ws2811) begin
      if (!prev_ws) rise_q.push_back(cyc);
      hi_run++;
      last_hi = cyc;
    end else if (prev_ws) begin
      if (hi_run != T0H && hi_run != T1H) bad_runs++;
      bits = {bits[6:0], hi_run == T1H};
      hi_run = 0;
      nbits++;
      if (nbits == 8) begin rxq.push_back(bits); nbits = 0; end
    end
    prev_ws = ws2811;
    bus.in_valid = src_en && fifo.size() != 0;
    bus.in_data = 8'($urandom);
    if (bus.in_valid) bus.in_data = fifo[0];
  endtask

  task automatic run_pops(input int n, input int budget);
    int j = 0;
    while (pop_ticks.size() < n && j < budget) begin tick(); j++; end
    chk("pops_reached", pop_ticks.size(), n);
  endtask

  task automatic run_fd(input int n, input int budget);
    int j = 0;
    while (n_fd < n && j < budget) begin tick(); j++; end
    chk("frame_done_count", n_fd, n);
  endtask

  task automatic check_bytes();
    chk("rx_byte_count", rxq.size(), txq.size());
    for (int i = 0; i < txq.size() && i < rxq.size(); i++)
      chk($sformatf("byte%0d", i), rxq[i], txq[i]);
    chk("pulse_widths", bad_runs, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ws2811", ws2811, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    // back-to-back frame with directed leading bytes
    clr();
    fifo.push_back(8'h80); fifo.push_back(8'h00); fifo.push_back(8'hFF);
    push_rand(3);
    src_en = 1'b1;
    run_pops(1, 10);
    chk("latency_high", ws2811, 1);
    run_fd(1, 3000);
    chk("busy_cycles", busy_cnt, FRAME * BYTE_T + RST_CYC);
    chk("frame_pops", pop_ticks.size(), FRAME);
    for (int i = 1; i < pop_ticks.size(); i++)
      chk("b2b_spacing", pop_ticks[i] - pop_ticks[i-1], BYTE_T);
    if (pop_ticks.size() == FRAME) chk("latch_end", fd_tick - pop_ticks[FRAME-1], BYTE_T + RST_CYC - 1);
    chk("latch_low", (fd_tick - last_hi) >= RST_CYC, 1);
    odd = 0;
    for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != BIT) odd++;
    chk("cell_period", odd, 0);
    chk("cell_count", rise_q.size(), FRAME * 8);
    check_bytes();
    tick();
    chk("fd_one_cycle", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", bus.in_ready, 1);
    // short underrun after byte 1
    clr();
    push_rand(FRAME);
    src_en = 1'b1;
    run_pops(2, 300);
    src_en = 1'b0;
    repeat (BYTE_T) tick();
    gap_hi = 0; gap_rdy = 0;
    repeat (200) begin tick(); gap_hi += int'(ws2811); gap_rdy += int'(bus.in_ready); end
    chk("gap_line_low", gap_hi, 0);
    chk("gap_ready", gap_rdy, 200);
    chk("gap_busy", busy, 1);
    src_en = 1'b1;
    run_fd(1, 3000);
    chk("short_no_underrun", n_ur, 0);
    check_bytes();
    // long underrun resyncs the frame
    clr();
    push_rand(2);
    src_en = 1'b1;
    run_pops(2, 300);
    p = pop_ticks[1];
    repeat (BYTE_T + 1100) tick();
    chk("long_underrun", n_ur, 1);
    chk("underrun_time", ur_tick - p, BYTE_T + RST_CYC);
    chk("underrun_idle", busy, 0);
    push_rand(FRAME);
    run_fd(1, 3000);
    chk("resync_pops", pop_ticks.size(), FRAME + 2);
    if (pop_ticks.size() == FRAME + 2) chk("resync_byte0", fd_tick - pop_ticks[FRAME+1], BYTE_T + RST_CYC - 1);
    chk("resync_one_underrun", n_ur, 1);
    check_bytes();
    // transfer arrives in the threshold cycle
    clr();
    push_rand(2);
    src_en = 1'b1;
    run_pops(2, 300);
    p = pop_ticks[1];
    src_en = 1'b0;
    repeat (BYTE_T + RST_CYC - 2) tick();
    push_rand(FRAME - 2);
    src_en = 1'b1;
    tick();
    tick();
    chk("race_pop_cycle", pop_ticks.size() == 3 ? pop_ticks[2] - p : -1, BYTE_T + RST_CYC);
    run_fd(1, 3000);
    chk("race_no_underrun", n_ur, 0);
    check_bytes();
    // asynchronous reset in the middle of a 1 bit
    clr();
    fifo.push_back(8'hFF);
    push_rand(FRAME - 1);
    src_en = 1'b1;
    run_pops(1, 10);
    repeat (6) tick();
    chk("pre_rst_high", ws2811, 1);
    src_en = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_ws_low", ws2811, 0);
    chk("async_ready", bus.in_ready, 1);
    chk("async_busy", busy, 0);
    repeat (2) tick();
    rst = 1'b0;
    fifo.delete();
    clr();
    push_rand(FRAME);
    src_en = 1'b1;
    run_fd(1, 3000);
    chk("post_rst_pops", pop_ticks.size(), FRAME);
    if (pop_ticks.size() == FRAME) chk("post_rst_byte0", fd_tick - pop_ticks[FRAME-1], BYTE_T + RST_CYC - 1);
    check_bytes();
    // random data with random short stalls across three frames
    clr();
    push_rand(3 * FRAME);
    k = 0;
    while (n_fd < 3 && k < 20000) begin
      src_en = $urandom_range(0, 3) != 0;
      tick();
      k++;
    end
    chk("rand_frames", n_fd, 3);
    chk("rand_no_underrun", n_ur, 0);
    check_bytes();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
